module_controle: RTL and testbench

//  Instruction sequencer for the Mini-CPU, directly upstream of module_alu.
//  - Accepts one 18-bit instruction at a time over a valid/ready handshake.
//  - Reads operands from an internal 8x16 register file and drives the ALU inputs.
//  - Holds the ALU inputs stable for the ALU's registered latency.
//  - Writes the ALU result back to the register file.
//  - Executes DISPLAY locally; DISPLAY never goes to the ALU.

---
 rtl/module_controle.sv | 155 +++++++++++++++
 tb/tb_module_controle.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_controle.sv
// Instruction sequencer for the Mini-CPU: fetches operands, drives module_alu, writes results back.
// Optional instruction counter port enabled by defining MODULE_CONTROLE_CONT_EN.
module module_controle #(
    parameter int ALU_LAT = 2,
    parameter int NREG    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] alu_saida,
    output logic [2:0]  opcode,
    output logic [15:0] valor1,
    output logic [15:0] valor2,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic [15:0] display,
    output logic        display_upd,
    output logic        busy
`ifdef MODULE_CONTROLE_CONT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_SHOW  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [17:0]   r_instr;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_rf [NREG];
    logic [2:0]    r_opcode;
    logic [15:0]   r_valor1;
    logic [15:0]   r_valor2;
    logic          r_sinal;
    logic [5:0]    r_imm;
    logic [15:0]   r_display;
    logic          r_display_upd;
    logic [15:0]   r_instr_count;

    logic [2:0]    w_rd;
    logic [2:0]    w_rs1;
    logic [2:0]    w_rs2;

    assign w_rd  = r_instr[14:12];
    assign w_rs1 = r_instr[11:9];
    assign w_rs2 = r_instr[8:6];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // WAIT lasts exactly ALU_LAT cycles: leave when the counter is about to hit zero.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_next = (instr[17:15] == OP_DISPLAY) ? S_SHOW : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == CW'(1)) w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            S_SHOW:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= '0;
            r_cnt         <= '0;
            r_opcode      <= OP_CLEAR;
            r_valor1      <= '0;
            r_valor2      <= '0;
            r_sinal       <= 1'b0;
            r_imm         <= '0;
            r_display     <= '0;
            r_display_upd <= 1'b0;
            r_instr_count <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_display_upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                    end
                end
                S_ISSUE: begin
                    r_opcode <= r_instr[17:15];
                    r_valor1 <= r_rf[w_rs1];
                    r_valor2 <= r_rf[w_rs2];
                    r_sinal  <= r_instr[6];
                    r_imm    <= r_instr[5:0];
                    r_cnt    <= CW'(ALU_LAT);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_WB: begin
                    r_rf[w_rd]    <= alu_saida;
                    r_instr_count <= r_instr_count + 16'd1;
                end
                S_SHOW: begin
                    // Pulse is registered so it lines up with the new display value.
                    r_display     <= r_rf[w_rs1];
                    r_display_upd <= 1'b1;
                    r_instr_count <= r_instr_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign opcode      = r_opcode;
    assign valor1      = r_valor1;
    assign valor2      = r_valor2;
    assign sinalImm    = r_sinal;
    assign Imm         = r_imm;
    assign display     = r_display;
    assign display_upd = r_display_upd;

`ifdef MODULE_CONTROLE_CONT_EN
    assign instr_count = r_instr_count;
`else
    logic w_unused_count;
    assign w_unused_count = ^r_instr_count;
`endif

endmodule

// File: tb/tb_module_controle.sv
// Bench for module_controle: table of ALU instructions with a display scoreboard,
// plus hand-written sequences for held-valid, mid-operation reset and the counter.
module tb_module_controle;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_saida;
  logic [2:0]  opcode;
  logic [15:0] valor1;
  logic [15:0] valor2;
  logic        sinalImm;
  logic [5:0]  Imm;
  logic [15:0] display;
  logic        display_upd;
  logic        busy;
`ifdef MODULE_CONTROLE_CONT_EN
  logic [15:0] instr_count;
`endif

  module_controle dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_saida   (alu_saida),
    .opcode      (opcode),
    .valor1      (valor1),
    .valor2      (valor2),
    .sinalImm    (sinalImm),
    .Imm         (Imm),
    .display     (display),
    .display_upd (display_upd),
    .busy        (busy)
`ifdef MODULE_CONTROLE_CONT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU model: two register stages from inputs to saida.
  logic [15:0] alu_s1;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic s,
                                        input logic [5:0] im);
    logic [15:0] iv;
    logic [15:0] r;
    iv = {10'b0, im};
    if (s) iv = -iv;
    case (op)
      3'd0:    r = iv;
      3'd1:    r = a + b;
      3'd2:    r = a + iv;
      3'd3:    r = a - b;
      3'd4:    r = a - iv;
      3'd5:    r = a * iv;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      alu_s1    <= '0;
      alu_saida <= '0;
    end else begin
      alu_s1    <= alu_f(opcode, valor1, valor2, sinalImm, Imm);
      alu_saida <= alu_s1;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic        prev_upd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Display scoreboard: every update must match the oldest pending expectation.
  always @(negedge clk) begin
    if (display_upd) begin
      check("upd_one_cycle", {31'b0, prev_upd}, 32'd0);
      if (exp_q.size() == 0) begin
        check("display_unexpected", 32'd1, 32'd0);
      end else begin
        check("display", {16'b0, display}, {16'b0, exp_q.pop_front()});
      end
    end
    prev_upd <= display_upd;
  end

  function automatic logic [17:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [5:0] im);
    return {op, rd, rs1, rs2, im};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [5:0]  imm;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[13];

  task automatic send(input logic [17:0] ins);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  task automatic run_alu(input vec_t v);
    send(mk(v.op, v.rd, v.rs1, v.rs2, v.imm));
    @(negedge clk);
    instr_valid = 1'b0;
    check("ready_issue", {31'b0, instr_ready}, 32'd0);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check("ready_wait", {31'b0, instr_ready}, 32'd0);
      check("opcode",     {29'b0, opcode}, {29'b0, v.op});
      check("valor1",     {16'b0, valor1}, {16'b0, v.v1});
      check("valor2",     {16'b0, valor2}, {16'b0, v.v2});
      check("sinalImm",   {31'b0, sinalImm}, {31'b0, v.rs2[0]});
      check("Imm",        {26'b0, Imm}, {26'b0, v.imm});
    end
    @(negedge clk);
    check("ready_wb", {31'b0, instr_ready}, 32'd0);
    check("busy_wb",  {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("ready_back", {31'b0, instr_ready}, 32'd1);
    check("busy_idle",  {31'b0, busy}, 32'd0);
    check("opcode_kept", {29'b0, opcode}, {29'b0, v.op});
  endtask

  task automatic show(input logic [2:0] rs1, input logic [15:0] exp);
    send(mk(3'd7, 3'd0, rs1, 3'd0, 6'd0));
    exp_q.push_back(exp);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ready_show", {31'b0, instr_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("display_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(negedge clk);
    check("upd_low", {31'b0, display_upd}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_opcode"}, {29'b0, opcode}, 32'd6);
    check({tag, "_valor1"}, {16'b0, valor1}, 32'd0);
    check({tag, "_valor2"}, {16'b0, valor2}, 32'd0);
    check({tag, "_sinal"},  {31'b0, sinalImm}, 32'd0);
    check({tag, "_imm"},    {26'b0, Imm}, 32'd0);
    check({tag, "_disp"},   {16'b0, display}, 32'd0);
    check({tag, "_upd"},    {31'b0, display_upd}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_busy",  {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    //              op    rd    rs1   rs2   imm    v1        v2        res
    vecs[0]  = '{3'd0, 3'd1, 3'd0, 3'd0, 6'd5,  16'h0000, 16'h0000, 16'h0005};
    vecs[1]  = '{3'd0, 3'd2, 3'd0, 3'd0, 6'd3,  16'h0000, 16'h0000, 16'h0003};
    vecs[2]  = '{3'd1, 3'd3, 3'd1, 3'd2, 6'd0,  16'h0005, 16'h0003, 16'h0008};
    vecs[3]  = '{3'd0, 3'd1, 3'd0, 3'd0, 6'd2,  16'h0000, 16'h0000, 16'h0002};
    vecs[4]  = '{3'd4, 3'd1, 3'd1, 3'd0, 6'd3,  16'h0002, 16'h0000, 16'hFFFF};
    vecs[5]  = '{3'd2, 3'd0, 3'd3, 3'd0, 6'd10, 16'h0008, 16'h0000, 16'h0012};
    vecs[6]  = '{3'd5, 3'd5, 3'd3, 3'd0, 6'd4,  16'h0008, 16'h0012, 16'h0020};
    vecs[7]  = '{3'd3, 3'd6, 3'd2, 3'd3, 6'd0,  16'h0003, 16'h0008, 16'hFFFB};
    vecs[8]  = '{3'd1, 3'd7, 3'd1, 3'd1, 6'd0,  16'hFFFF, 16'hFFFF, 16'hFFFE};
    vecs[9]  = '{3'd6, 3'd1, 3'd0, 3'd0, 6'd0,  16'h0012, 16'h0012, 16'h0000};
    vecs[10] = '{3'd2, 3'd2, 3'd2, 3'd1, 6'd1,  16'h0003, 16'h0000, 16'h0002};
    vecs[11] = '{3'd0, 3'd4, 3'd0, 3'd0, 6'd7,  16'h0012, 16'h0012, 16'h0007};
    vecs[12] = '{3'd5, 3'd3, 3'd3, 3'd1, 6'd2,  16'h0008, 16'h0000, 16'hFFF0};

    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    do_reset();
    check("rst_display_r", {16'b0, display}, 32'd0);

    for (int k = 0; k < 13; k++) begin
      run_alu(vecs[k]);
      show(vecs[k].rd, vecs[k].res);
    end

    // Held valid during a running ADD: second copy is taken only once back in IDLE.
    send(mk(3'd1, 3'd4, 3'd4, 3'd2, 6'd0));
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      lat++;
    end
    check("held_ready_low_cycles", lat, 32'd4);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("held_second_accept", {31'b0, instr_ready}, 32'd0);
    wait_idle("held_second_timeout");
    repeat (3) @(negedge clk);
    check("held_no_extra", {31'b0, busy}, 32'd0);
    show(3'd4, 16'h000B);

    // Reset in WAIT of a MUL: instruction abandoned, register file cleared.
    send(mk(3'd5, 3'd4, 3'd4, 3'd0, 6'd3));
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_ready", {31'b0, instr_ready}, 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_opcode", {29'b0, opcode}, 32'd6);
    show(3'd4, 16'h0000);
    show(3'd1, 16'h0000);

`ifdef MODULE_CONTROLE_CONT_EN
    do_reset();
    check("cnt_reset", {16'b0, instr_count}, 32'd0);
    run_alu(vecs[0]);
    run_alu(vecs[1]);
    run_alu(vecs[2]);
    show(3'd3, 16'h0008);
    check("cnt_four", {16'b0, instr_count}, 32'd4);
    @(negedge clk);
    force dut.r_instr_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_instr_count;
    show(3'd3, 16'h0008);
    check("cnt_ffff", {16'b0, instr_count}, 32'hFFFF);
    show(3'd3, 16'h0008);
    check("cnt_wrap", {16'b0, instr_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
